// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type and default constants.
// Optional feature macro used by the receiver: UART_RX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO, shared by the UART rx/tx paths.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    push request / data (ignored when full unless popping too)
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry, 0 while empty
//   empty, full       occupancy flags
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr, w_rd;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                 (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_wr = wr_en && (!full || rd_en);
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a receive FIFO.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   rx             serial input (idle high, asynchronous)
//   rd_en          pop FIFO head
//   rd_data        FIFO head (first-word fall-through), empty flags validity
//   empty, full    FIFO flags
//   frame_err      1-cycle pulse, stop bit sampled low
//   parity_err     1-cycle pulse, parity mismatch (0 when parity disabled)
//   overflow       sticky, a byte was dropped on a full FIFO
//   clr_overflow   clears overflow (a same-cycle new overflow wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      rd_en,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      empty,
  output logic                      full,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      r_rx_meta, r_rx_s;
  rx_state_t                 r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err;
  logic                      r_overflow;

  logic w_bit_end, w_half, w_stop_smp, w_par_bad, w_push;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_bit_end  = (r_cnt == BIT_M1);
  assign w_half     = (r_cnt == HALF_M1);
  assign w_stop_smp = (r_state == ST_STOP) && w_bit_end;
  assign w_push     = w_stop_smp && r_rx_s && !w_par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          if (w_half) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            // A line already back high at mid start bit is a glitch.
            r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          // Leaving at mid stop bit gives margin for baud mismatch and
          // lets a back-to-back start edge be caught.
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // Absorb a break so it reports only one framing error.
          r_cnt <= '0;
          if (r_rx_s) r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err;

  // Even parity: data bits XOR parity bit must be 0. Held until the stop
  // sample so both error kinds are reported together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == ST_START)
        r_par_bad <= 1'b0;
      else if (r_state == ST_PARITY && w_bit_end)
        r_par_bad <= r_rx_s ^ (^r_shift);
      r_parity_err <= w_stop_smp && r_par_bad;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_stop_smp && !r_rx_s;
      if (w_push && full && !rd_en) r_overflow <= 1'b1;
      else if (clr_overflow)        r_overflow <= 1'b0;
    end
  end

  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

  uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_push),
    .wr_data (r_shift),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Stimulus pushes expected bytes into a queue; a monitor pops and compares
// whenever a pop is accepted. Optional UART_RX_PARITY_EN scenario included.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PUSH_EDGE = 155 + CPB;
`else
  localparam int PUSH_EDGE = 155;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, parity_err, overflow;

  int         checks = 0;
  int         errors = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) step();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) step();
`endif
    rx = stop_b;
    repeat (CPB) step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  // Monitor: counts error pulses and checks every accepted pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected none", rd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_data", 32'(rd_data), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    check("rst_empty",      32'(empty),      32'd1);
    check("rst_full",       32'(full),       32'd0);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    rst_n = 1'b1;
    repeat (5) step();

    // 1: single byte, exact push latency
    exp_q.push_back(8'hA5);
    fork
      send(8'hA5, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) step();
        check("t1_empty_before_push", 32'(empty), 32'd1);
        step();
        check("t1_empty_after_push", 32'(empty), 32'd0);
      end
    join
    check("t1_rd_data", 32'(rd_data), 32'hA5);
    pop();
    check("t1_empty_after_pop", 32'(empty), 32'd1);

    // 2: short glitch is a false start
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (40) step();
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_no_ferr", 32'(n_ferr), 32'd0);

    // 3: framing error followed by a break, then recovery
    send(8'h3C, 1'b0);
    repeat (40 * CPB) step();
    rx = 1'b1;
    repeat (2 * CPB) step();
    check("t3_one_ferr", 32'(n_ferr), 32'd1);
    check("t3_empty", 32'(empty), 32'd1);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    repeat (4) step();
    check("t3_recv", 32'(empty), 32'd0);
    pop();

    // 4: fill, overflow, drain, clear
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(8'(v));
      send(8'(v), 1'b1);
    end
    check("t4_full", 32'(full), 32'd1);
    check("t4_no_ovf_yet", 32'(overflow), 32'd0);
    send(8'h05, 1'b1);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_still_full", 32'(full), 32'd1);
    repeat (4) pop();
    check("t4_drained", 32'(empty), 32'd1);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // 5: push and pop in the same cycle while full
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(8'(v));
      send(8'(v), 1'b1);
    end
    check("t5_full", 32'(full), 32'd1);
    exp_q.push_back(8'h06);
    fork
      send(8'h06, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
      end
    join
    check("t5_no_overflow", 32'(overflow), 32'd0);
    check("t5_full_kept", 32'(full), 32'd1);
    repeat (4) pop();
    check("t5_drained", 32'(empty), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 6: good and bad parity
    par_flip = 1'b0;
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1);
    repeat (4) step();
    check("t6_good_pushed", 32'(empty), 32'd0);
    pop();
    check("t6_no_perr", 32'(n_perr), 32'd0);
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    repeat (4) step();
    check("t6_one_perr", 32'(n_perr), 32'd1);
    check("t6_bad_dropped", 32'(empty), 32'd1);
    check("t6_no_new_ferr", 32'(n_ferr), 32'd1);
`else
    check("no_parity_err", 32'(n_perr), 32'd0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
